keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 27000; clk cycles per column slot and per debounce sample (1 ms at 27 MHz).
REQ-002 Parameter DEB_SAMPLES, default 20; consecutive identical samples needed to accept a press or a release.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 row  input  4  keypad row lines, active-low, pulled up externally, asynchronous to clk.
REQ-006 col  output  4  column drive, active-low, exactly one bit low at any time.
REQ-007 keypad_pressed  output  1  high while a debounced key is held, until its release is debounced.
REQ-008 key  output  5  code of the held key, 0-9 digits, A=10 B=11 C=12 D=13 *=14 #=15, 31 when no key is held.
REQ-009 key_strobe  output  1  one-cycle pulse when a new press is accepted.

Function
REQ-010 row SHALL pass through a 2-FF synchronizer; all decisions use the synchronized value rows_s.
REQ-011 A tick counter SHALL run 0..SCAN_DIV-1 and wrap; a tick is the cycle where the counter equals SCAN_DIV-1; rows_s is sampled only on ticks.
REQ-012 Layout (row r0..r3 × col c0..c3): r0 = 1 2 3 A, r1 = 4 5 6 B, r2 = 7 8 9 C, r3 = * 0 # D.
REQ-013 States: SCAN, DEBOUNCE, PRESSED, RELEASE; the state encoding and a sample counter of at least ceil(log2(DEB_SAMPLES+1)) bits.
REQ-014 SCAN, tick, rows_s = 1111: col rotates left (1110→1101→1011→0111→1110).
REQ-015 SCAN, tick, exactly one row low: latch candidate (row, col), set sample count to 1, go to DEBOUNCE, hold col.
REQ-016 SCAN, tick, two or more rows low: treat as invalid, advance col, stay in SCAN.
REQ-017 DEBOUNCE, tick: same single row low → increment count; when count reaches DEB_SAMPLES → PRESSED. Any other pattern → SCAN with col advanced.
REQ-018 On the DEBOUNCE→PRESSED transition, keypad_pressed=1, key=decoded code and key_strobe=1 SHALL all be registered and visible in the cycle after the accepting tick; key_strobe drops the following cycle.
REQ-019 PRESSED, tick: candidate row low → stay. Candidate row high → RELEASE with count=1. Other rows in the frozen column are ignored.
REQ-020 RELEASE, tick: candidate row high → increment count; at DEB_SAMPLES go to SCAN, keypad_pressed=0, key=31, advance col (visible in the cycle after the tick).
REQ-021 RELEASE, tick, candidate row low again → PRESSED with no new key_strobe; keypad_pressed stays 1 throughout RELEASE.
REQ-022 Holding a key SHALL produce exactly one key_strobe (no auto-repeat).
REQ-023 key SHALL be stable whenever keypad_pressed=1.

Reset
REQ-024 rst_n low SHALL asynchronously force state=SCAN, col=1110, keypad_pressed=0, key=31, key_strobe=0, tick and sample counters=0, synchronizer FFs=1111.
REQ-025 Reset asserted mid-press SHALL drop keypad_pressed immediately; after release of reset, a still-held key SHALL be re-debounced and SHALL produce a fresh key_strobe.

Structure
REQ-026 The following SHALL live in shared package keypad_pkg: key code constants (KEY_0..KEY_9, KEY_A=10, KEY_B=11, KEY_C=12, KEY_D=13, KEY_STAR=14, KEY_HASH=15, KEY_NONE=31) and the state enum.
REQ-027 The row synchronizer SHALL be sub-module keypad_sync (parameterised-width 2-FF synchronizer); code decode SHALL be an in-module function.

Verification (SCAN_DIV=4, DEB_SAMPLES=3)
REQ-028 Reset release with row=1111 → col sequence 1110,1101,1011,0111 repeating, each held 4 cycles; keypad_pressed=0, key=31.
REQ-029 row=1011 held while col=1101 → after 3 ticks, key=8, keypad_pressed=1, single-cycle key_strobe; col frozen at 1101.
REQ-030 Press "A" (r0, c3) with 1-tick glitch high during DEBOUNCE → return to SCAN, no strobe; press held cleanly → key=10 accepted.
REQ-031 Held key "#" (r3, c2), row bounces high 1 tick then low → remains PRESSED, key=15, no second strobe; full release of 3 ticks → keypad_pressed=0, key=31.
REQ-032 row=0011 (two rows low) at any column → no strobe, col keeps advancing.
REQ-033 rst_n pulsed low while key "5" (r1, c1) is held → outputs clear immediately; after reset, key=5 is re-accepted with a new strobe after 3 ticks.

Source files
------------

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared key codes, scanner state enum and row/column helpers
// Ports: none (package).
package keypad_pkg;

    localparam int KEY_W = 5;

    localparam logic [KEY_W-1:0] KEY_0    = 5'd0;
    localparam logic [KEY_W-1:0] KEY_1    = 5'd1;
    localparam logic [KEY_W-1:0] KEY_2    = 5'd2;
    localparam logic [KEY_W-1:0] KEY_3    = 5'd3;
    localparam logic [KEY_W-1:0] KEY_4    = 5'd4;
    localparam logic [KEY_W-1:0] KEY_5    = 5'd5;
    localparam logic [KEY_W-1:0] KEY_6    = 5'd6;
    localparam logic [KEY_W-1:0] KEY_7    = 5'd7;
    localparam logic [KEY_W-1:0] KEY_8    = 5'd8;
    localparam logic [KEY_W-1:0] KEY_9    = 5'd9;
    localparam logic [KEY_W-1:0] KEY_A    = 5'd10;
    localparam logic [KEY_W-1:0] KEY_B    = 5'd11;
    localparam logic [KEY_W-1:0] KEY_C    = 5'd12;
    localparam logic [KEY_W-1:0] KEY_D    = 5'd13;
    localparam logic [KEY_W-1:0] KEY_STAR = 5'd14;
    localparam logic [KEY_W-1:0] KEY_HASH = 5'd15;
    localparam logic [KEY_W-1:0] KEY_NONE = 5'd31;

    localparam logic [3:0] COL_RESET = 4'b1110;

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_PRESSED,
        ST_RELEASE
    } state_t;

    // True when exactly one of the four active-low lines is asserted.
    function automatic logic is_single_low(input logic [3:0] v);
        return (v == 4'b1110) || (v == 4'b1101) || (v == 4'b1011) || (v == 4'b0111);
    endfunction

    // Index of the single low line; only meaningful when is_single_low(v).
    function automatic logic [1:0] low_index(input logic [3:0] v);
        logic [1:0] idx;
        case (v)
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    function automatic logic [3:0] rotl(input logic [3:0] v);
        return {v[2:0], v[3]};
    endfunction

endpackage

// File: rtl/keypad_if.sv
// rtl/keypad_if.sv - keypad matrix lines and decoded key outputs
// Signals: row (4, active-low rows in), col (4, active-low column drive),
//          keypad_pressed (key held), key (5-bit code), key_strobe (new press pulse).
// Modports: master = scanner side, slave = keypad/consumer side.
interface keypad_if;

    logic [3:0] row;
    logic [3:0] col;
    logic       keypad_pressed;
    logic [4:0] key;
    logic       key_strobe;

    modport master (
        input  row,
        output col,
        output keypad_pressed,
        output key,
        output key_strobe
    );

    modport slave (
        output row,
        input  col,
        input  keypad_pressed,
        input  key,
        input  key_strobe
    );

endinterface

// File: rtl/keypad_sync.sv
// rtl/keypad_sync.sv - parameterised-width 2-FF synchronizer with settable reset value
// Ports: clk, rst_n (async active-low), d (async input bus), q (synchronized bus).
module keypad_sync #(
    parameter int              WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with debounced press/release
// Ports: clk, rst_n (async active-low), bus (keypad_if.master: row in, col,
//        keypad_pressed, key, key_strobe out).
// Params: SCAN_DIV = clk cycles per scan/debounce tick, DEB_SAMPLES = samples to accept.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV    = 27000,
    parameter int DEB_SAMPLES = 20
) (
    input  logic     clk,
    input  logic     rst_n,
    keypad_if.master bus
);

    localparam int TICK_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int SAMP_W = (DEB_SAMPLES > 1) ? $clog2(DEB_SAMPLES + 1) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_DIV - 1);
    localparam logic [SAMP_W-1:0] SAMP_DONE = SAMP_W'(DEB_SAMPLES);

    logic [3:0]        rows_s;
    logic [TICK_W-1:0] tick_cnt;
    logic              tick;

    state_t            state;
    logic [3:0]        col_r;
    logic [1:0]        cand_row;
    logic [1:0]        cand_col;
    logic [SAMP_W-1:0] samp_cnt;
    logic              pressed_r;
    logic [KEY_W-1:0]  key_r;
    logic              strobe_r;

    logic [SAMP_W-1:0] samp_next;
    logic              cand_only_low;
    logic              cand_high;

    // Row index in bits [3:2], column index in [1:0].
    function automatic logic [KEY_W-1:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [KEY_W-1:0] code;
        case ({r, c})
            4'h0:    code = KEY_1;
            4'h1:    code = KEY_2;
            4'h2:    code = KEY_3;
            4'h3:    code = KEY_A;
            4'h4:    code = KEY_4;
            4'h5:    code = KEY_5;
            4'h6:    code = KEY_6;
            4'h7:    code = KEY_B;
            4'h8:    code = KEY_7;
            4'h9:    code = KEY_8;
            4'hA:    code = KEY_9;
            4'hB:    code = KEY_C;
            4'hC:    code = KEY_STAR;
            4'hD:    code = KEY_0;
            4'hE:    code = KEY_HASH;
            default: code = KEY_D;
        endcase
        return code;
    endfunction

    keypad_sync #(
        .WIDTH     (4),
        .RESET_VAL (4'b1111)
    ) u_row_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.row),
        .q     (rows_s)
    );

    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign samp_next     = samp_cnt + 1'b1;
    // Debounce requires the candidate row to be the only one low; during a
    // hold only the candidate row matters, other rows in the column are ignored.
    assign cand_only_low = (rows_s == ~(4'b0001 << cand_row));
    assign cand_high     = rows_s[cand_row];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_SCAN;
            col_r     <= COL_RESET;
            cand_row  <= '0;
            cand_col  <= '0;
            samp_cnt  <= '0;
            pressed_r <= 1'b0;
            key_r     <= KEY_NONE;
            strobe_r  <= 1'b0;
        end else begin
            strobe_r <= 1'b0;
            if (tick) begin
                case (state)
                    ST_SCAN: begin
                        if (is_single_low(rows_s)) begin
                            // Column is held so the candidate key stays driven.
                            cand_row <= low_index(rows_s);
                            cand_col <= low_index(col_r);
                            if (DEB_SAMPLES <= 1) begin
                                state     <= ST_PRESSED;
                                pressed_r <= 1'b1;
                                key_r     <= key_code(low_index(rows_s), low_index(col_r));
                                strobe_r  <= 1'b1;
                                samp_cnt  <= '0;
                            end else begin
                                state    <= ST_DEBOUNCE;
                                samp_cnt <= SAMP_W'(1);
                            end
                        end else begin
                            // Idle or multi-key ghosting: keep scanning.
                            col_r <= rotl(col_r);
                        end
                    end

                    ST_DEBOUNCE: begin
                        if (cand_only_low) begin
                            if (samp_next == SAMP_DONE) begin
                                state     <= ST_PRESSED;
                                pressed_r <= 1'b1;
                                key_r     <= key_code(cand_row, cand_col);
                                strobe_r  <= 1'b1;
                                samp_cnt  <= '0;
                            end else begin
                                samp_cnt <= samp_next;
                            end
                        end else begin
                            state    <= ST_SCAN;
                            col_r    <= rotl(col_r);
                            samp_cnt <= '0;
                        end
                    end

                    ST_PRESSED: begin
                        if (cand_high) begin
                            if (DEB_SAMPLES <= 1) begin
                                state     <= ST_SCAN;
                                pressed_r <= 1'b0;
                                key_r     <= KEY_NONE;
                                col_r     <= rotl(col_r);
                                samp_cnt  <= '0;
                            end else begin
                                state    <= ST_RELEASE;
                                samp_cnt <= SAMP_W'(1);
                            end
                        end
                    end

                    ST_RELEASE: begin
                        if (cand_high) begin
                            if (samp_next == SAMP_DONE) begin
                                state     <= ST_SCAN;
                                pressed_r <= 1'b0;
                                key_r     <= KEY_NONE;
                                col_r     <= rotl(col_r);
                                samp_cnt  <= '0;
                            end else begin
                                samp_cnt <= samp_next;
                            end
                        end else begin
                            // Bounce back to held: same key, so no new strobe.
                            state    <= ST_PRESSED;
                            samp_cnt <= '0;
                        end
                    end

                    default: begin
                        state    <= ST_SCAN;
                        samp_cnt <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.col            = col_r;
    assign bus.keypad_pressed = pressed_r;
    assign bus.key            = key_r;
    assign bus.key_strobe     = strobe_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed self-checking bench for keypad_scanner
// Ports: none (top-level bench).
module tb_keypad_scanner;
    import keypad_pkg::*;

    logic clk;
    logic rst_n;
    int   cyc;
    int   strobe_cnt;
    int   checks;
    int   errors;

    logic       held_en;
    logic [1:0] held_row;
    logic [1:0] held_col;
    logic       force_en;
    logic [3:0] force_val;
    logic [3:0] row_drv;
    logic [3:0] col_seq [4];

    keypad_if bus ();

    keypad_scanner #(
        .SCAN_DIV    (4),
        .DEB_SAMPLES (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad model: a held key pulls its row low only while its column is driven.
    always_comb begin
        row_drv = 4'b1111;
        if (force_en) begin
            row_drv = force_val;
        end else if (held_en && (bus.col[held_col] == 1'b0)) begin
            row_drv = ~(4'b0001 << held_row);
        end
    end
    assign bus.row = row_drv;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(posedge clk) begin
        if (bus.key_strobe) strobe_cnt <= strobe_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic go_to(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic press(input logic [1:0] r, input logic [1:0] c);
        held_row = r;
        held_col = c;
        held_en  = 1'b1;
    endtask

    task automatic release_key();
        held_en = 1'b0;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        strobe_cnt = 0;
        held_en    = 1'b0;
        held_row   = 2'd0;
        held_col   = 2'd0;
        force_en   = 1'b0;
        force_val  = 4'b1111;
        col_seq    = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        rst_n      = 1'b0;

        repeat (3) @(negedge clk);
        check_eq("rst_col", bus.col, 4'b1110);
        check_eq("rst_pressed", bus.keypad_pressed, 1'b0);
        check_eq("rst_key", bus.key, KEY_NONE);
        check_eq("rst_strobe", bus.key_strobe, 1'b0);

        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            check_eq("scan_col", bus.col, col_seq[(cyc / 4) % 4]);
        end
        check_eq("idle_pressed", bus.keypad_pressed, 1'b0);
        check_eq("idle_key", bus.key, KEY_NONE);

        // Key 8 at r2/c1.
        press(2'd2, 2'd1);
        go_to(31);
        check_eq("k8_pre_strobe", bus.key_strobe, 1'b0);
        check_eq("k8_pre_pressed", bus.keypad_pressed, 1'b0);
        go_to(32);
        check_eq("k8_strobe", bus.key_strobe, 1'b1);
        check_eq("k8_key", bus.key, KEY_8);
        check_eq("k8_pressed", bus.keypad_pressed, 1'b1);
        check_eq("k8_col", bus.col, 4'b1101);
        go_to(33);
        check_eq("k8_strobe_drop", bus.key_strobe, 1'b0);
        check_eq("k8_key_hold", bus.key, KEY_8);
        go_to(52);
        check_eq("k8_one_strobe", strobe_cnt, 1);
        check_eq("k8_col_frozen", bus.col, 4'b1101);
        release_key();
        go_to(63);
        check_eq("k8_rel_pressed", bus.keypad_pressed, 1'b1);
        check_eq("k8_rel_key", bus.key, KEY_8);
        go_to(64);
        check_eq("k8_done_pressed", bus.keypad_pressed, 1'b0);
        check_eq("k8_done_key", bus.key, KEY_NONE);
        check_eq("k8_done_col", bus.col, 4'b1011);

        // Key A at r0/c3 with a one-tick glitch during debounce.
        press(2'd0, 2'd3);
        go_to(73);
        release_key();
        go_to(77);
        press(2'd0, 2'd3);
        go_to(80);
        check_eq("kA_glitch_pressed", bus.keypad_pressed, 1'b0);
        check_eq("kA_glitch_col", bus.col, 4'b1101);
        go_to(99);
        check_eq("kA_glitch_nostrobe", strobe_cnt, 1);
        go_to(100);
        check_eq("kA_strobe", bus.key_strobe, 1'b1);
        check_eq("kA_key", bus.key, KEY_A);
        go_to(101);
        release_key();
        go_to(112);
        check_eq("kA_done_pressed", bus.keypad_pressed, 1'b0);
        check_eq("kA_done_col", bus.col, 4'b1110);

        // Key # at r3/c2, bounce high for one tick while held.
        press(2'd3, 2'd2);
        go_to(132);
        check_eq("kH_strobe", bus.key_strobe, 1'b1);
        check_eq("kH_key", bus.key, KEY_HASH);
        go_to(137);
        release_key();
        go_to(141);
        press(2'd3, 2'd2);
        go_to(145);
        check_eq("kH_bounce_pressed", bus.keypad_pressed, 1'b1);
        check_eq("kH_bounce_key", bus.key, KEY_HASH);
        go_to(150);
        check_eq("kH_no_restrobe", strobe_cnt, 3);
        release_key();
        go_to(163);
        check_eq("kH_rel_pressed", bus.keypad_pressed, 1'b1);
        go_to(164);
        check_eq("kH_done_pressed", bus.keypad_pressed, 1'b0);
        check_eq("kH_done_key", bus.key, KEY_NONE);
        check_eq("kH_done_col", bus.col, 4'b0111);

        // Two rows low: invalid, scanning continues.
        force_val = 4'b0011;
        force_en  = 1'b1;
        go_to(169);
        check_eq("multi_col1", bus.col, 4'b1110);
        go_to(181);
        check_eq("multi_col4", bus.col, 4'b0111);
        check_eq("multi_nostrobe", strobe_cnt, 3);
        check_eq("multi_pressed", bus.keypad_pressed, 1'b0);
        force_en = 1'b0;

        // Key 5 at r1/c1, then reset while held.
        press(2'd1, 2'd1);
        go_to(200);
        check_eq("k5_strobe", bus.key_strobe, 1'b1);
        check_eq("k5_key", bus.key, KEY_5);
        go_to(210);
        rst_n = 1'b0;
        #1;
        check_eq("k5_rst_pressed", bus.keypad_pressed, 1'b0);
        check_eq("k5_rst_key", bus.key, KEY_NONE);
        check_eq("k5_rst_col", bus.col, 4'b1110);
        @(negedge clk);
        rst_n = 1'b1;
        go_to(15);
        check_eq("k5_re_pre_strobe", bus.key_strobe, 1'b0);
        go_to(16);
        check_eq("k5_re_strobe", bus.key_strobe, 1'b1);
        check_eq("k5_re_key", bus.key, KEY_5);
        check_eq("k5_re_pressed", bus.keypad_pressed, 1'b1);
        go_to(17);
        check_eq("total_strobes", strobe_cnt, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
